// File: rtl/enc8b10b_multilane.sv
// -----------------------------------------------------------------------------
// enc8b10b_multilane
//   NBYTES-wide 8b/10b encoder (IEEE 802.3 cl.36 code tables). One running
//   disparity is chained lane 0 -> lane NBYTES-1 inside a single cycle, then
//   registered. The output stage is a one-deep valid/ready register, so the
//   serialiser can stall it.
//
// Parameters
//   NBYTES   bytes encoded per cycle (1..8); lane 0 is transmitted first
//   RD_INIT  running disparity after reset (0 = RD-, 1 = RD+)
//
// Ports
//   CLK        rising-edge clock
//   RESET_N    asynchronous active-low reset
//   IN_VALID   DATAIN/KI valid
//   IN_READY   encoder accepts this cycle (!OUT_VALID || OUT_READY)
//   KI         per-lane control flag (1 = K symbol)
//   DATAIN     lane n = DATAIN[8n+7:8n], bit0 = A .. bit7 = H
//   OUT_VALID  DATAOUT valid
//   OUT_READY  downstream takes DATAOUT
//   DATAOUT    lane n = DATAOUT[10n+9:10n], bit0..9 = a,b,c,d,e,i,f,g,h,j
//   RD_OUT     running disparity after the last lane of DATAOUT
//   K_ERR      (only with ENC8B10B_KERR_EN) lane had KI=1 on a byte that is
//              not a legal K code; such bytes are always encoded as data
//
// Optional feature macro: ENC8B10B_KERR_EN
// -----------------------------------------------------------------------------

// Single-lane combinational encoder.
module enc8b10b_lane (
    input  logic [7:0] din,
    input  logic       k,
    input  logic       rd_in,
    output logic [9:0] code,
    output logic       rd_out
`ifdef ENC8B10B_KERR_EN
    ,
    output logic       kerr
`endif
);
    logic [4:0] x;
    logic [2:0] y;
    logic       kvalid;
    logic       k28;
    logic [5:0] c6;      // RD- form of the 6b code, a at bit 5
    logic [3:0] c4;      // RD- form of the 4b code, f at bit 3
    logic [5:0] s6;
    logic [3:0] s4;
    logic       unbal6;
    logic       unbal4;
    logic       rd_mid;  // disparity between the 6b and 4b sub-blocks
    logic       alt7;

    assign x      = din[4:0];
    assign y      = din[7:5];
    assign kvalid = k && ((x == 5'd28) ||
                          ((y == 3'd7) && ((x == 5'd23) || (x == 5'd27) ||
                                           (x == 5'd29) || (x == 5'd30))));
    assign k28    = kvalid && (x == 5'd28);

`ifdef ENC8B10B_KERR_EN
    assign kerr = k && !kvalid;
`endif

    always_comb begin
        c6 = 6'b000000;
        case (x)
            5'd0:  c6 = 6'b100111;
            5'd1:  c6 = 6'b011101;
            5'd2:  c6 = 6'b101101;
            5'd3:  c6 = 6'b110001;
            5'd4:  c6 = 6'b110101;
            5'd5:  c6 = 6'b101001;
            5'd6:  c6 = 6'b011001;
            5'd7:  c6 = 6'b111000;
            5'd8:  c6 = 6'b111001;
            5'd9:  c6 = 6'b100101;
            5'd10: c6 = 6'b010101;
            5'd11: c6 = 6'b110100;
            5'd12: c6 = 6'b001101;
            5'd13: c6 = 6'b101100;
            5'd14: c6 = 6'b011100;
            5'd15: c6 = 6'b010111;
            5'd16: c6 = 6'b011011;
            5'd17: c6 = 6'b100011;
            5'd18: c6 = 6'b010011;
            5'd19: c6 = 6'b110010;
            5'd20: c6 = 6'b001011;
            5'd21: c6 = 6'b101010;
            5'd22: c6 = 6'b011010;
            5'd23: c6 = 6'b111010;
            5'd24: c6 = 6'b110011;
            5'd25: c6 = 6'b100110;
            5'd26: c6 = 6'b010110;
            5'd27: c6 = 6'b110110;
            5'd28: c6 = k28 ? 6'b001111 : 6'b001110;
            5'd29: c6 = 6'b101110;
            5'd30: c6 = 6'b011110;
            default: c6 = 6'b101011;
        endcase
    end

    // Unbalanced codes (and the balanced-but-alternating D.7) are inverted at RD+.
    assign unbal6 = ($countones(c6) != 3);
    assign s6     = (rd_in && (unbal6 || (x == 5'd7))) ? ~c6 : c6;
    assign rd_mid = rd_in ^ unbal6;

    // A7 replaces P7 where P7 would create a run of five equal bits.
    assign alt7 = kvalid ||
                  (!rd_mid && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20))) ||
                  ( rd_mid && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14)));

    always_comb begin
        c4 = 4'b0000;
        case (y)
            3'd0: c4 = 4'b1011;
            3'd1: c4 = 4'b1001;
            3'd2: c4 = 4'b0101;
            3'd3: c4 = 4'b1100;
            3'd4: c4 = 4'b1101;
            3'd5: c4 = 4'b1010;
            3'd6: c4 = 4'b0110;
            default: c4 = alt7 ? 4'b0111 : 4'b1110;
        endcase
    end

    assign unbal4 = ($countones(c4) != 2);

    // K28.y inverts its balanced 4b codes relative to data when entering at RD+
    // (i.e. rd_mid is RD-), which keeps the comma property.
    always_comb begin
        s4 = c4;
        if (rd_mid && (unbal4 || (y == 3'd3)))
            s4 = ~c4;
        else if (k28 && !rd_mid &&
                 ((y == 3'd1) || (y == 3'd2) || (y == 3'd5) || (y == 3'd6)))
            s4 = ~c4;
    end

    assign rd_out = rd_mid ^ unbal4;
    assign code   = {s4[0], s4[1], s4[2], s4[3],
                     s6[0], s6[1], s6[2], s6[3], s6[4], s6[5]};
endmodule

module enc8b10b_multilane #(
    parameter int NBYTES  = 2,
    parameter bit RD_INIT = 1'b0
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    input  logic                   IN_VALID,
    output logic                   IN_READY,
    input  logic [NBYTES-1:0]      KI,
    input  logic [8*NBYTES-1:0]    DATAIN,
    output logic                   OUT_VALID,
    input  logic                   OUT_READY,
    output logic [10*NBYTES-1:0]   DATAOUT,
    output logic                   RD_OUT
`ifdef ENC8B10B_KERR_EN
    ,
    output logic [NBYTES-1:0]      K_ERR
`endif
);
    logic [NBYTES-1:0][9:0] code_nxt;
    logic                   rd_last;
    logic                   accept;
`ifdef ENC8B10B_KERR_EN
    logic [NBYTES-1:0]      kerr_nxt;
`endif

    assign IN_READY = !OUT_VALID || OUT_READY;
    assign accept   = IN_VALID && IN_READY;

    // RD_OUT doubles as the running-disparity register: it always holds the RD
    // left by the last accepted word, which is where the next word starts.
    // Per-block rd signals keep the disparity chain as distinct nets.
    for (genvar g = 0; g < NBYTES; g++) begin : g_lane
        logic rd_i;
        logic rd_o;
        if (g == 0) begin : g_first
            assign rd_i = RD_OUT;
        end else begin : g_next
            assign rd_i = g_lane[g-1].rd_o;
        end
        enc8b10b_lane u_lane (
            .din    (DATAIN[8*g +: 8]),
            .k      (KI[g]),
            .rd_in  (rd_i),
            .code   (code_nxt[g]),
            .rd_out (rd_o)
`ifdef ENC8B10B_KERR_EN
            ,
            .kerr   (kerr_nxt[g])
`endif
        );
    end

    assign rd_last = g_lane[NBYTES-1].rd_o;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            OUT_VALID <= 1'b0;
            DATAOUT   <= '0;
            RD_OUT    <= RD_INIT;
`ifdef ENC8B10B_KERR_EN
            K_ERR     <= '0;
`endif
        end else if (accept) begin
            OUT_VALID <= 1'b1;
            DATAOUT   <= code_nxt;
            RD_OUT    <= rd_last;
`ifdef ENC8B10B_KERR_EN
            K_ERR     <= kerr_nxt;
`endif
        end else if (OUT_READY) begin
            OUT_VALID <= 1'b0;
        end
    end
endmodule

// File: tb/tb_enc8b10b_multilane.sv
module tb_enc8b10b_multilane;
    localparam int NB = 2;
    localparam int NWORDS = 3000;

    logic           CLK = 1'b0;
    logic           RESET_N = 1'b0;
    logic           IN_VALID = 1'b0;
    logic           OUT_READY = 1'b0;
    logic           IN_READY;
    logic           OUT_VALID;
    logic           RD_OUT;
    logic [NB-1:0]  KI = '0;
    logic [8*NB-1:0] DATAIN = '0;
    logic [10*NB-1:0] DATAOUT;
`ifdef ENC8B10B_KERR_EN
    logic [NB-1:0]  K_ERR;
`endif

    always #5 CLK = ~CLK;

    enc8b10b_multilane #(.NBYTES(NB), .RD_INIT(1'b0)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .KI(KI), .DATAIN(DATAIN), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .DATAOUT(DATAOUT), .RD_OUT(RD_OUT)
`ifdef ENC8B10B_KERR_EN
        , .K_ERR(K_ERR)
`endif
    );

    int vecs = 0;
    int errs = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Reference model: published cl.36 code tables, abcdei / fghj written a/f first.
    bit [5:0] T6N [32] = '{6'b100111,6'b011101,6'b101101,6'b110001,6'b110101,6'b101001,6'b011001,6'b111000,
                          6'b111001,6'b100101,6'b010101,6'b110100,6'b001101,6'b101100,6'b011100,6'b010111,
                          6'b011011,6'b100011,6'b010011,6'b110010,6'b001011,6'b101010,6'b011010,6'b111010,
                          6'b110011,6'b100110,6'b010110,6'b110110,6'b001110,6'b101110,6'b011110,6'b101011};
    bit [5:0] T6P [32] = '{6'b011000,6'b100010,6'b010010,6'b110001,6'b001010,6'b101001,6'b011001,6'b000111,
                          6'b000110,6'b100101,6'b010101,6'b110100,6'b001101,6'b101100,6'b011100,6'b101000,
                          6'b100100,6'b100011,6'b010011,6'b110010,6'b001011,6'b101010,6'b011010,6'b000101,
                          6'b001100,6'b100110,6'b010110,6'b001001,6'b001110,6'b010001,6'b100001,6'b010100};
    bit [3:0] T4N [8] = '{4'b1011,4'b1001,4'b0101,4'b1100,4'b1101,4'b1010,4'b0110,4'b1110};
    bit [3:0] T4P [8] = '{4'b0100,4'b1001,4'b0101,4'b0011,4'b0010,4'b1010,4'b0110,4'b0001};
    // K28.y 4b part indexed by the RD before the whole symbol
    bit [3:0] K4N [8] = '{4'b0100,4'b1001,4'b0101,4'b0011,4'b0010,4'b1010,4'b0110,4'b1000};
    bit [3:0] K4P [8] = '{4'b1011,4'b0110,4'b1010,4'b1100,4'b1101,4'b0101,4'b1001,4'b0111};
    bit [7:0] KBYTES [12] = '{8'h1C,8'h3C,8'h5C,8'h7C,8'h9C,8'hBC,8'hDC,8'hFC,8'hF7,8'hFB,8'hFD,8'hFE};

    bit m_rd = 1'b0;

    function automatic bit is_k(input logic [7:0] b);
        is_k = 1'b0;
        for (int i = 0; i < 12; i++) if (b == KBYTES[i]) is_k = 1'b1;
    endfunction

    function automatic logic [9:0] enc_sym(input logic [7:0] b, input bit k, input bit rd);
        int x, y;
        bit kv, alt, rd6;
        bit [5:0] p6;
        bit [3:0] p4;
        logic [9:0] s;
        x = int'(b[4:0]);
        y = int'(b[7:5]);
        kv = k && is_k(b);
        p6 = rd ? T6P[x] : T6N[x];
        if (kv && x == 28) p6 = rd ? 6'b110000 : 6'b001111;
        rd6 = ($countones(p6) == 3) ? rd : !rd;
        if (kv && x == 28) p4 = rd ? K4P[y] : K4N[y];
        else if (y == 7) begin
            alt = kv || (!rd6 && (x == 17 || x == 18 || x == 20)) ||
                  (rd6 && (x == 11 || x == 13 || x == 14));
            p4 = alt ? (rd6 ? 4'b1000 : 4'b0111) : (rd6 ? 4'b0001 : 4'b1110);
        end else p4 = rd6 ? T4P[y] : T4N[y];
        for (int i = 0; i < 6; i++) s[i] = p6[5-i];
        for (int i = 0; i < 4; i++) s[6+i] = p4[3-i];
        return s;
    endfunction

    // Encodes one word from m_rd and advances m_rd by whole-symbol disparity.
    task automatic model_word(input logic [15:0] d, input logic [1:0] k,
                              output logic [19:0] w, output logic [1:0] ke);
        logic [9:0] sym;
        for (int l = 0; l < NB; l++) begin
            sym = enc_sym(d[8*l +: 8], k[l], m_rd);
            w[10*l +: 10] = sym;
            ke[l] = k[l] && !is_k(d[8*l +: 8]);
            if ($countones(sym) != 5) m_rd = !m_rd;
        end
    endtask

    typedef struct {
        logic [15:0] din;
        logic [1:0]  ki;
        logic [19:0] dout;
        logic        rd;
        logic [1:0]  kerr;
    } vec_t;

    typedef struct {
        logic [19:0] w;
        logic        rd;
        logic [1:0]  ke;
    } exp_t;

    vec_t tbl [10];
    exp_t q [$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [19:0] wa, wb, w;
        logic [1:0] ke;
        logic rda, rdb;
        exp_t e;
        int cyc, sent;
        bit hold_chk, acc_last;
        logic [19:0] held_w;
        logic held_rd;

        tbl[0] = '{16'hBCBC, 2'b11, 20'hA0D7C, 1'b0, 2'b00};
        tbl[1] = '{16'hB5B5, 2'b00, 20'h55555, 1'b0, 2'b00};
        tbl[2] = '{16'h0000, 2'b01, 20'h2E4B9, 1'b0, 2'b01};
        tbl[3] = '{16'hB5BC, 2'b01, 20'h5557C, 1'b1, 2'b00};
        tbl[4] = '{16'hB5B5, 2'b00, 20'h55555, 1'b1, 2'b00};
        tbl[5] = '{16'h0000, 2'b01, 20'hD1B46, 1'b1, 2'b01};
        tbl[6] = '{16'hBCBC, 2'b11, 20'h5F283, 1'b1, 2'b00};
        tbl[7] = '{16'hF7F7, 2'b11, 20'hEA3A8, 1'b1, 2'b00};
        tbl[8] = '{16'hF7F7, 2'b00, 20'h7A1E8, 1'b1, 2'b00};
        tbl[9] = '{16'hEBEB, 2'b00, 20'h72C4B, 1'b1, 2'b00};

        // Reset state
        repeat (3) @(negedge CLK);
        chk("rst_out_valid", OUT_VALID, 0);
        chk("rst_dataout", DATAOUT, 0);
        chk("rst_rd_out", RD_OUT, 0);
        chk("rst_in_ready", IN_READY, 1);
`ifdef ENC8B10B_KERR_EN
        chk("rst_k_err", K_ERR, 0);
`endif
        RESET_N = 1'b1;
        OUT_READY = 1'b1;

        // Directed vectors, one word at a time, RD chained through the table
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            IN_VALID = 1'b1; DATAIN = tbl[i].din; KI = tbl[i].ki;
            @(negedge CLK);
            IN_VALID = 1'b0;
            chk($sformatf("tbl%0d_valid", i), OUT_VALID, 1);
            chk($sformatf("tbl%0d_data", i), DATAOUT, tbl[i].dout);
            chk($sformatf("tbl%0d_rd", i), RD_OUT, tbl[i].rd);
`ifdef ENC8B10B_KERR_EN
            chk($sformatf("tbl%0d_kerr", i), K_ERR, tbl[i].kerr);
`endif
        end
        m_rd = 1'b1;

        // Backpressure: 5 stalled cycles with the next word waiting upstream
        @(negedge CLK);
        OUT_READY = 1'b0;
        IN_VALID = 1'b1; DATAIN = 16'hB5B5; KI = 2'b00;
        model_word(DATAIN, KI, wa, ke); rda = m_rd;
        @(negedge CLK);
        DATAIN = 16'hF7BC; KI = 2'b11;
        model_word(DATAIN, KI, wb, ke); rdb = m_rd;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_valid", OUT_VALID, 1);
            chk("stall_in_ready", IN_READY, 0);
            chk("stall_data", DATAOUT, wa);
            chk("stall_rd", RD_OUT, rda);
            @(negedge CLK);
        end
        OUT_READY = 1'b1;
        #1 chk("unstall_in_ready", IN_READY, 1);
        @(negedge CLK);
        IN_VALID = 1'b0;
        chk("unstall_data", DATAOUT, wb);
        chk("unstall_rd", RD_OUT, rdb);
        @(negedge CLK);
        chk("drain_valid", OUT_VALID, 0);

        // Reset while a word is held and RD is +
        OUT_READY = 1'b0;
        IN_VALID = 1'b1; DATAIN = 16'hB5BC; KI = 2'b01;
        model_word(DATAIN, KI, wa, ke);
        @(negedge CLK);
        IN_VALID = 1'b0;
        chk("pre_rst_valid", OUT_VALID, 1);
        chk("pre_rst_rd", RD_OUT, m_rd);
        chk("pre_rst_data", DATAOUT, wa);
        RESET_N = 1'b0;
        #1;
        chk("mid_rst_valid", OUT_VALID, 0);
        chk("mid_rst_data", DATAOUT, 0);
        chk("mid_rst_rd", RD_OUT, 0);
        @(negedge CLK);
        RESET_N = 1'b1;
        m_rd = 1'b0;
        OUT_READY = 1'b1;
        IN_VALID = 1'b1; DATAIN = 16'hBCBC; KI = 2'b11;
        model_word(DATAIN, KI, wa, ke);
        @(negedge CLK);
        IN_VALID = 1'b0;
        chk("post_rst_data", DATAOUT, 20'hA0D7C);
        chk("post_rst_rd", RD_OUT, 0);

        // Random traffic with random backpressure against the model
        cyc = 0; sent = 0; hold_chk = 0; acc_last = 0;
        held_w = '0; held_rd = 1'b0;
        while ((sent < NWORDS || q.size() != 0 || OUT_VALID) && cyc < 20000) begin
            @(negedge CLK);
            cyc++;
            if (hold_chk) begin
                chk("hold_data", DATAOUT, held_w);
                chk("hold_rd", RD_OUT, held_rd);
            end
            if (acc_last) IN_VALID = 1'b0;
            OUT_READY = ($urandom_range(0, 9) < 7);
            if (!IN_VALID && sent < NWORDS && $urandom_range(0, 3) != 0) begin
                for (int l = 0; l < NB; l++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        DATAIN[8*l +: 8] = KBYTES[$urandom_range(0, 11)];
                        KI[l] = 1'b1;
                    end else begin
                        DATAIN[8*l +: 8] = 8'($urandom);
                        KI[l] = ($urandom_range(0, 7) == 0);
                    end
                end
                IN_VALID = 1'b1;
            end
            #1;
            chk("rnd_in_ready", IN_READY, !OUT_VALID || OUT_READY);
            if (OUT_VALID && OUT_READY) begin
                if (q.size() == 0) begin
                    vecs++; errs++;
                    $display("FAIL rnd_extra_word: got %h expected no word", DATAOUT);
                end else begin
                    e = q.pop_front();
                    chk("rnd_data", DATAOUT, e.w);
                    chk("rnd_rd", RD_OUT, e.rd);
`ifdef ENC8B10B_KERR_EN
                    chk("rnd_kerr", K_ERR, e.ke);
`endif
                end
            end
            hold_chk = OUT_VALID && !OUT_READY;
            held_w = DATAOUT;
            held_rd = RD_OUT;
            acc_last = IN_VALID && IN_READY;
            if (acc_last) begin
                model_word(DATAIN, KI, w, ke);
                e.w = w; e.rd = m_rd; e.ke = ke;
                q.push_back(e);
                sent++;
            end
        end
        IN_VALID = 1'b0;
        if (cyc >= 20000) begin
            vecs++; errs++;
            $display("FAIL rnd_timeout: sent %0d, %0d words still expected", sent, q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
